// File: rtl/trap_filter_mc.sv
// trap_filter_mc: multi-channel trapezoidal shaping filter with runtime k/l/m.
// Each channel keeps its own sample history and p/s accumulators; samples are
// time-interleaved and tagged with a channel index.
// Pipeline: A (difference d, history shift) -> B (p += d, r) -> C (s += r, out).
// Build option: define TRAP_SATURATE_EN to clamp out_data to the OUT_W range;
// otherwise out_data wraps to the low OUT_W bits of s >>> SHIFT.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   in_valid/in_ch/in_data  sample strobe, channel tag, signed sample
//   in_ready              sample acceptance (low on any cfg_wr cycle)
//   cfg_wr/cfg_k/cfg_l/cfg_m  config strobe and shaping parameters
//   cfg_err               sticky flag for rejected config writes
//   out_valid/out_ch/out_data  shaped result strobe, channel tag, value
module trap_filter_mc #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned NCH       = 4,
  parameter int unsigned MAX_DEPTH = 64,
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned SHIFT     = 4,
  localparam int unsigned CH_W     = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int unsigned KL_W     = $clog2(MAX_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  input  logic                     cfg_wr,
  input  logic [KL_W-1:0]          cfg_k,
  input  logic [KL_W-1:0]          cfg_l,
  input  logic [7:0]               cfg_m,
  output logic                     cfg_err,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [OUT_W-1:0]  out_data
);

  localparam int unsigned IDX_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  logic [KL_W-1:0]          k_q, l_q;
  logic [7:0]               m_q;
  logic                     rdy_q;

  // hist[c][i] holds x(n-1-i) of channel c relative to the incoming sample
  logic signed [DATA_W-1:0] hist [NCH][MAX_DEPTH];
  logic signed [ACC_W-1:0]  p_acc [NCH];
  logic signed [ACC_W-1:0]  s_acc [NCH];

  logic                     a_valid, b_valid;
  logic [CH_W-1:0]          a_ch, b_ch;
  logic signed [ACC_W-1:0]  a_d, b_r;

  logic                     cfg_ok_c, ch_ok_c, accept_c;
  logic [CH_W-1:0]          ch_idx_c;
  logic [KL_W:0]            sum_kl_c;
  logic [IDX_W-1:0]         idx_k_c, idx_l_c, idx_kl_c;
  logic signed [ACC_W-1:0]  d_c, m_ext_c, p_new_c, r_c, s_new_c;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_W-1:0] v);
    return ACC_W'(v);
  endfunction

`ifdef TRAP_SATURATE_EN
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic signed [OUT_W-1:0] shape_out(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] sh;
    sh = s >>> SHIFT;
    if (sh > OUT_MAX)      return {1'b0, {(OUT_W-1){1'b1}}};
    else if (sh < OUT_MIN) return {1'b1, {(OUT_W-1){1'b0}}};
    else                   return OUT_W'(sh);
  endfunction
`else
  function automatic logic signed [OUT_W-1:0] shape_out(input logic signed [ACC_W-1:0] s);
    return OUT_W'(s >>> SHIFT);
  endfunction
`endif

  // A config write takes priority over a sample presented in the same cycle,
  // so ready is gated by cfg_wr directly rather than a cycle late.
  assign in_ready = rdy_q & ~cfg_wr;

  // Config validation, channel check and stage-A difference taps
  always_comb begin
    cfg_ok_c = cfg_wr && (cfg_k != '0) && (cfg_k <= cfg_l)
               && (({1'b0, cfg_k} + {1'b0, cfg_l}) <= (KL_W+1)'(MAX_DEPTH));
    ch_ok_c  = 32'(in_ch) < NCH;
    ch_idx_c = ch_ok_c ? in_ch : '0;
    accept_c = in_valid && in_ready && ch_ok_c;
    sum_kl_c = {1'b0, k_q} + {1'b0, l_q};
    idx_k_c  = IDX_W'(k_q - KL_W'(1));
    idx_l_c  = IDX_W'(l_q - KL_W'(1));
    idx_kl_c = IDX_W'(sum_kl_c - (KL_W+1)'(1));
    d_c      = sext(in_data) - sext(hist[ch_idx_c][idx_k_c])
               - sext(hist[ch_idx_c][idx_l_c]) + sext(hist[ch_idx_c][idx_kl_c]);
  end

  // Stage B/C accumulator updates
  always_comb begin
    m_ext_c = ACC_W'({1'b0, m_q});
    p_new_c = p_acc[a_ch] + a_d;
    r_c     = p_new_c + m_ext_c * a_d;
    s_new_c = s_acc[b_ch] + b_r;
  end

  // Configuration registers, ready and sticky error
  always_ff @(posedge clk) begin
    if (!reset) begin
      k_q     <= KL_W'(1);
      l_q     <= KL_W'(1);
      m_q     <= '0;
      rdy_q   <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (cfg_ok_c) begin
        k_q   <= cfg_k;
        l_q   <= cfg_l;
        m_q   <= cfg_m;
        rdy_q <= 1'b0;
      end else if (cfg_wr) begin
        cfg_err <= 1'b1;
      end
    end
  end

  // Per-channel history: shifts only for the channel of an accepted sample
  always_ff @(posedge clk) begin
    if (!reset || cfg_ok_c) begin
      for (int c = 0; c < NCH; c++)
        for (int i = 0; i < MAX_DEPTH; i++)
          hist[c][i] <= '0;
    end else if (accept_c) begin
      for (int c = 0; c < NCH; c++) begin
        if (ch_idx_c == CH_W'(c)) begin
          hist[c][0] <= in_data;
          for (int i = 1; i < MAX_DEPTH; i++)
            hist[c][i] <= hist[c][i-1];
        end
      end
    end
  end

  // Three-stage datapath; reset or accepted config drops everything in flight
  always_ff @(posedge clk) begin
    if (!reset || cfg_ok_c) begin
      a_valid   <= 1'b0;
      b_valid   <= 1'b0;
      out_valid <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        p_acc[c] <= '0;
        s_acc[c] <= '0;
      end
      if (!reset) begin
        a_ch     <= '0;
        a_d      <= '0;
        b_ch     <= '0;
        b_r      <= '0;
        out_ch   <= '0;
        out_data <= '0;
      end
    end else begin
      a_valid <= accept_c;
      if (accept_c) begin
        a_ch <= ch_idx_c;
        a_d  <= d_c;
      end
      b_valid <= a_valid;
      if (a_valid) begin
        p_acc[a_ch] <= p_new_c;
        b_ch        <= a_ch;
        b_r         <= r_c;
      end
      out_valid <= b_valid;
      if (b_valid) begin
        s_acc[b_ch] <= s_new_c;
        out_ch      <= b_ch;
        out_data    <= shape_out(s_new_c);
      end
    end
  end

endmodule

// File: tb/tb_trap_filter_mc.sv
// tb_trap_filter_mc: scoreboard bench for trap_filter_mc (NCH=3 build).
// The driver pushes hand-computed expected results; a monitor pops and
// compares on every out_valid, including the 3-cycle latency.
module tb_trap_filter_mc;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               in_valid = 1'b0;
  logic [1:0]         in_ch = '0;
  logic signed [11:0] in_data = '0;
  logic               in_ready;
  logic               cfg_wr = 1'b0;
  logic [6:0]         cfg_k = '0;
  logic [6:0]         cfg_l = '0;
  logic [7:0]         cfg_m = '0;
  logic               cfg_err;
  logic               out_valid;
  logic [1:0]         out_ch;
  logic signed [15:0] out_data;

  trap_filter_mc #(.NCH(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data), .in_ready(in_ready),
    .cfg_wr(cfg_wr), .cfg_k(cfg_k), .cfg_l(cfg_l), .cfg_m(cfg_m), .cfg_err(cfg_err),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ch;
    int data;
    int at;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  exp_t d_e;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected output from a hand-computed s>>>4 value
  function automatic int conv(input int v);
    logic signed [15:0] t;
`ifdef TRAP_SATURATE_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    t = 16'(v);
    return int'(t);
`endif
  endfunction

  // Monitor: compare every presented result against the scoreboard head
  always begin
    @(posedge clk);
    #1;
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        m_e = sb.pop_front();
        check("out_data", int'(out_data), m_e.data);
        check("out_ch", int'(out_ch), m_e.ch);
        check("latency_cycle", cyc, m_e.at);
      end
    end else if (sb.size() != 0 && sb[0].at < cyc) begin
      check("missing_out_valid", 0, 1);
      void'(sb.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      cfg_wr   = 1'b0;
    end
  endtask

  task automatic send(input int ch, input int x, input bit has_out, input int exp_data);
    @(negedge clk);
    cfg_wr   = 1'b0;
    in_valid = 1'b1;
    in_ch    = 2'(ch);
    in_data  = 12'(x);
    if (has_out) begin
      d_e.ch   = ch;
      d_e.data = exp_data;
      d_e.at   = cyc + 3;
      sb.push_back(d_e);
    end
    #1 check("in_ready_send", int'(in_ready), 1);
  endtask

  task automatic cfg(input int k, input int l, input int m, input bit ok);
    @(negedge clk);
    in_valid = 1'b0;
    cfg_wr   = 1'b1;
    cfg_k    = 7'(k);
    cfg_l    = 7'(l);
    cfg_m    = 8'(m);
    if (ok) sb.delete();
    #1 check("in_ready_cfg_cycle", int'(in_ready), 0);
    @(negedge clk);
    cfg_wr = 1'b0;
    #1 check("in_ready_after_cfg", int'(in_ready), ok ? 0 : 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_ch", int'(out_ch), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int step_exp[6];
    int neg_exp[6];
    int sat_exp[6];
    step_exp = '{6, 18, 31, 43, 50, 50};
    neg_exp  = '{-4, -10, -16, -22, -25, -25};
    sat_exp  = '{32752, 65631, 33135, 511, 511, 511};

    // Power-on reset
    repeat (2) @(posedge clk);
    #1 check_reset_outputs();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 check("in_ready_after_reset", int'(in_ready), 1);

    // Step response, k=2 l=4 m=0
    cfg(2, 4, 0, 1'b1);
    for (int i = 0; i < 8; i++) send(0, 100, 1'b1, (i < 6) ? step_exp[i] : 50);
    idle(4);

    // Channel isolation: ch0=100, ch1=0, ch2=-50 interleaved
    cfg(2, 4, 0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      send(0, 100, 1'b1, step_exp[i]);
      send(1, 0, 1'b1, 0);
      send(2, -50, 1'b1, neg_exp[i]);
    end

    // Rejected config k=5 l=3: error flag, shaping continues unchanged
    cfg(5, 3, 0, 1'b0);
    check("cfg_err_set", int'(cfg_err), 1);
    send(0, 100, 1'b1, 50);
    send(1, 0, 1'b1, 0);
    send(2, -50, 1'b1, -25);
    send(0, 100, 1'b1, 50);
    send(0, 100, 1'b1, 50);

    // Reconfig mid-stream: the two in-flight ch0 results are dropped
    cfg(2, 4, 0, 1'b1);
    check("cfg_err_sticky", int'(cfg_err), 1);
    send(0, 100, 1'b1, 6);
    send(0, 100, 1'b1, 18);

    // Out-of-range channel is ignored; fresh ch2 shows state was cleared
    send(0, 100, 1'b1, 31);
    send(3, 1000, 1'b0, 0);
    send(0, 100, 1'b1, 43);
    send(0, 100, 1'b1, 50);
    send(1, 0, 1'b1, 0);
    send(2, -50, 1'b1, -4);
    idle(4);

    // Output range: k=2 l=2 m=255 with full-scale input
    cfg(2, 2, 255, 1'b1);
    for (int i = 0; i < 6; i++) send(0, 2047, 1'b1, conv(sat_exp[i]));
    idle(4);

    // Reset while results are in flight
    cfg(2, 2, 255, 1'b1);
    send(0, 100, 1'b1, 1600);
    send(0, 100, 1'b1, 3206);
    send(0, 100, 1'b1, 1618);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    sb.delete();
    @(posedge clk);
    #1 check_reset_outputs();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 check("in_ready_after_mid_reset", int'(in_ready), 1);
    idle(5);

    // Default config after reset: k=1 l=1 m=0
    send(0, 100, 1'b1, 6);
    send(0, 100, 1'b1, 6);
    send(0, 100, 1'b1, 6);
    send(1, 0, 1'b1, 0);
    idle(1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) check("scoreboard_drain", sb.size(), 0);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
